// File: rtl/muldiv_ctrl.sv
// Iterative MIPS multiply/divide unit: owns HI/LO and runs MULT/MULTU/DIV/DIVU
// over WIDTH+1 cycles (WIDTH iterations plus one sign-fixup cycle).
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request that is accepted only when busy=0 (IDLE);
    // while busy=1 a start or hilo_rd raises stall and the requester re-presents.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic               is_div_q;
    logic               sign_a;
    logic               sign_b;
    logic               bzero;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   dvs;
    logic [2*WIDTH-1:0] acc;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    // rem < divisor always holds, so bit WIDTH of div_diff is exactly the borrow.
    always_comb begin
        mul_add  = acc[0] ? dvs : '0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        div_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_sh - {1'b0, dvs};
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (bzero) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_hi = sign_a ? -rem : rem;
                res_lo = (sign_a ^ sign_b) ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            bzero    <= 1'b0;
            a_orig   <= '0;
            dvs      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        sign_a   <= is_signed & a[WIDTH-1];
                        sign_b   <= is_signed & b[WIDTH-1];
                        bzero    <= (b == '0);
                        a_orig   <= a;
                        dvs      <= op[1] ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt      <= CNT_INIT;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO only change at the fixup edge or via MTHI/MTLO in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign stall     = busy & (start | hilo_rd);
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: random and directed mult/div ops scored against a
// 64-bit arithmetic reference, plus latency, hazard, MTHI/MTLO and reset checks.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        hilo_rd;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hilo_rd(hilo_rd),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 0) return {x, 32'hffffffff};
                q = sx / sy;
                r = sx % sy;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (y == 0) return {x, 32'hffffffff};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hi", {32'b0, hi}, {32'b0, e[63:32]});
                chk("result_lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
    end

    // mode 0: plain; 1: MTHI/MTLO poke while busy; 2: MTHI/MTLO together with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int mode);
        int          n;
        logic [63:0] e;
        e = model(o, x, y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (mode == 2) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'ha5a5_a5a5;
        end
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (mode == 2 && n == 1) begin
                hi_we = 1'b0;
                lo_we = 1'b0;
                chk("mt_with_start_hi", {32'b0, hi}, 64'ha5a5_a5a5);
                chk("mt_with_start_lo", {32'b0, lo}, 64'ha5a5_a5a5);
                cur_hi = 32'ha5a5_a5a5;
                cur_lo = 32'ha5a5_a5a5;
            end
            if (mode == 1 && n == 5) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'hdead_beef;
            end
            if (mode == 1 && n == 6) begin
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            if (n == 20) begin
                chk("hold_hi_mid_run", {32'b0, hi}, {32'b0, cur_hi});
                chk("hold_lo_mid_run", {32'b0, lo}, {32'b0, cur_lo});
            end
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("done_pulse_on", {63'b0, done}, 64'd1);
        @(negedge clk);
        chk("done_pulse_off", {63'b0, done}, 64'd0);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
    endtask

    initial begin
        logic [63:0] e;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        a       = '0;
        b       = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        hilo_rd = 1'b0;
        #12;
        start   = 1'b1;
        hilo_rd = 1'b1;
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_stall", {63'b0, stall}, 64'd0);
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        chk("reset_state", {62'b0, dbg_state}, 64'd0);
        start   = 1'b0;
        hilo_rd = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        hilo_rd = 1'b1;
        #1;
        chk("idle_no_stall", {63'b0, stall}, 64'd0);
        hilo_rd = 1'b0;

        // MTHI / MTLO in IDLE
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", {32'b0, hi}, 64'h1234);
        chk("mthi_lo_kept", {32'b0, lo}, 64'h0);
        lo_we = 1'b1;
        wdata = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", {32'b0, lo}, 64'h5678);
        chk("mtlo_hi_kept", {32'b0, hi}, 64'h1234);
        cur_hi = 32'h1234;
        cur_lo = 32'h5678;

        // Directed ops
        run_op(2'd1, 32'hffff_ffff, 32'hffff_ffff, 0);
        chk("multu_max_hi", {32'b0, hi}, 64'hffff_fffe);
        chk("multu_max_lo", {32'b0, lo}, 64'h0000_0001);
        run_op(2'd0, 32'hffff_fffd, 32'd7, 1);
        chk("mult_neg_lo", {32'b0, lo}, 64'hffff_ffeb);
        run_op(2'd2, 32'hffff_fff9, 32'd2, 0);
        chk("div_neg_lo", {32'b0, lo}, 64'hffff_fffd);
        chk("div_neg_hi", {32'b0, hi}, 64'hffff_ffff);
        run_op(2'd3, 32'd100, 32'd0, 2);
        chk("divu_zero_lo", {32'b0, lo}, 64'hffff_ffff);
        chk("divu_zero_hi", {32'b0, hi}, 64'd100);
        run_op(2'd2, 32'h8000_0000, 32'hffff_ffff, 0);
        chk("div_wrap_lo", {32'b0, lo}, 64'h8000_0000);
        chk("div_wrap_hi", {32'b0, hi}, 64'h0);

        // Hazards: hilo_rd at k=5 and k=33, re-issued start at k=10, read at done
        e = model(2'd1, 32'd123456, 32'd789);
        @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd123456;
        b     = 32'd789;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            if (k == 5 || k == 33) begin
                hilo_rd = 1'b1;
                #1;
                chk("stall_on_hilo_rd", {63'b0, stall}, 64'd1);
            end
            if (k == 6) hilo_rd = 1'b0;
            if (k == 10) begin
                start = 1'b1;
                op    = 2'd2;
                a     = 32'd999;
                b     = 32'd3;
                #1;
                chk("stall_on_start", {63'b0, stall}, 64'd1);
            end
            if (k == 11) start = 1'b0;
            if (k == 20) begin
                chk("hazard_hold_hi", {32'b0, hi}, {32'b0, cur_hi});
                chk("hazard_hold_lo", {32'b0, lo}, {32'b0, cur_lo});
            end
            if (k == 34) begin
                hilo_rd = 1'b1;
                #1;
                chk("no_stall_at_done", {63'b0, stall}, 64'd0);
                chk("done_at_34", {63'b0, done}, 64'd1);
                chk("read_new_lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
            if (k == 35) begin
                hilo_rd = 1'b0;
                chk("second_start_ignored", {63'b0, busy}, 64'd0);
                chk("done_single_cycle", {63'b0, done}, 64'd0);
            end
            @(negedge clk);
        end
        cur_hi = e[63:32];
        cur_lo = e[31:0];

        // Reset in the middle of a MULT aborts it
        start = 1'b1;
        op    = 2'd0;
        a     = 32'hffff_fffb;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cur_hi = '0;
        cur_lo = '0;
        run_op(2'd1, 32'd6, 32'd7, 0);
        chk("post_reset_lo", {32'b0, lo}, 64'd42);
        chk("post_reset_hi", {32'b0, hi}, 64'd0);

        // Random ops
        for (int i = 0; i < 24; i++) begin
            ro  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            ra  = (sel == 9) ? 32'h8000_0000 : $urandom;
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hffff_ffff;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, (i % 5 == 3) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the pipelined MIPS core; executes MULT, MULTU, DIV and DIVU off the single-cycle ALU path.
- Owns the architectural HI/LO registers and serves MTHI/MTLO writes.
- Issues a stall to the hazard unit while an operation is in flight and a dependent instruction (MFHI/MFLO or a new mult/div) reaches EX.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  issue request for a mult/div op from EX
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- hilo_rd  input  1  MFHI/MFLO currently in EX
- busy  output  1  operation in flight
- done  output  1  one-cycle completion pulse
- stall  output  1  freeze IF/ID/EX
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0): state IDLE; hi=0, lo=0, busy=0, done=0, stall=0; iteration counter=0. Reset mid-operation aborts the operation with no HI/LO update.
- FSM states: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1: latch op; latch |a|, |b| for signed ops, raw a, b for unsigned; latch sign_a, sign_b, the original a, and a b==0 flag. Load counter with WIDTH-1 and go to RUN. busy rises next cycle.
- RUN: one iteration per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When counter==0, go to FIX; otherwise decrement.
- FIX: one cycle; compute final results and load hi/lo at the end-of-cycle edge, then go to IDLE.
  - MULT: negate the 2*WIDTH product if sign_a^sign_b. hi=upper WIDTH bits, lo=lower WIDTH bits.
  - MULTU: product unmodified.
  - DIV: lo=quotient, negated if sign_a^sign_b; hi=remainder, negated if sign_a.
  - DIVU: quotient and remainder unmodified.
  - Divide by zero (DIV or DIVU): lo=all ones, hi=original a. Same latency as any other op.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Latency: start sampled at edge E0 gives new hi/lo visible after edge E0+WIDTH+1 (33 edges for WIDTH=32).
  - busy=1 for the WIDTH+1 cycles following E0.
  - done=1 for exactly the one cycle after E0+WIDTH+1, when busy is already 0.
- stall = busy & (start | hilo_rd). Combinational; never asserted in IDLE.
- start while busy: ignored; the requester is held by stall and re-presents start.
- hi_we/lo_we: in IDLE, load wdata at the clock edge. While busy, ignored (the hazard unit guarantees they do not occur).
- start together with hi_we/lo_we in IDLE: the write takes effect, and the op result later overwrites both registers.
- hi and lo hold their values between updates. Outputs stay stable during RUN, so reads never observe partial results.
- Counter width is clog2(WIDTH). No arithmetic overflow flags are produced.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done is a single 1-cycle pulse; busy high for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0; both with the same 33-edge latency.
- Hazards: hilo_rd=1 at cycles 5 and 33 after start -> stall=1 at both; hilo_rd=1 at the done cycle -> stall=0 and lo shows the new value. A second start while busy is ignored; no result changes until the first op completes.
- MTHI wdata=0x1234 in IDLE -> hi=0x1234 next cycle; hi_we asserted while busy -> hi unchanged.
- reset_n pulsed low at iteration 10 of a MULT -> busy, done, hi and lo go to 0 immediately. A fresh MULTU 6*7 afterward gives lo=42, hi=0.
